// File: rtl/imm_rot_encoder.sv
// Sequential rotated-immediate encoder: scans one even rotation per cycle and
// reports the lowest-rot {rot, imm8} encoding of a captured 32-bit constant.
module imm_rot_encoder #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_value_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_ok_o,
    output logic [11:0] rsp_imm12_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e      state_q, state_d;
    logic [3:0]  r_q, r_d;
    logic [31:0] val_q, val_d;
    logic        match_q, match_d;
    logic [11:0] imm12_q, imm12_d;

    logic [4:0]  shamt;
    logic [31:0] cand;
    logic        hit;

    // val_q rotated left by 2*r; a shift of 32 yields 0, so r=0 passes val_q through
    assign shamt = {r_q, 1'b0};
    assign cand  = (val_q << shamt) | (val_q >> (6'd32 - {1'b0, shamt}));
    assign hit   = (cand[31:8] == 24'd0);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        val_d   = val_q;
        match_d = match_q;
        imm12_d = imm12_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d = SCAN;
                    val_d   = req_value_i;
                    r_d     = 4'd0;
                    match_d = 1'b0;
                    imm12_d = 12'd0;
                end
            end
            SCAN: begin
                // only the first (lowest r) match is kept
                if (hit && !match_q) begin
                    match_d = 1'b1;
                    imm12_d = {r_q, cand[7:0]};
                end
                if (r_q == 4'd15 || (EARLY_EXIT && hit)) begin
                    state_d = DONE;
                end else begin
                    r_d = r_q + 4'd1;
                end
            end
            DONE: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                    r_d     = 4'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            r_q     <= 4'd0;
            val_q   <= 32'd0;
            match_q <= 1'b0;
            imm12_q <= 12'd0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            val_q   <= val_d;
            match_q <= match_d;
            imm12_q <= imm12_d;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign rsp_valid_o = (state_q == DONE);
    assign rsp_ok_o    = match_q;
    assign rsp_imm12_o = imm12_q;

endmodule

// File: tb/tb_imm_rot_encoder.sv
// Bench for imm_rot_encoder: an early-exit and a fixed-latency instance share
// stimulus and are checked against a rotation-search reference model.
module tb_imm_rot_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_value;
    logic        rsp_ready_a, rsp_ready_b;

    logic        req_ready_a, rsp_valid_a, rsp_ok_a, busy_a;
    logic        req_ready_b, rsp_valid_b, rsp_ok_b, busy_b;
    logic [11:0] imm12_a, imm12_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    imm_rot_encoder #(.EARLY_EXIT(1'b1)) dut_a (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready_a), .req_value_i(req_value),
        .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready_a),
        .rsp_ok_o(rsp_ok_a), .rsp_imm12_o(imm12_a), .busy_o(busy_a)
    );

    imm_rot_encoder #(.EARLY_EXIT(1'b0)) dut_b (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready_b), .req_value_i(req_value),
        .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready_b),
        .rsp_ok_o(rsp_ok_b), .rsp_imm12_o(imm12_b), .busy_o(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Search every even right-rotation for an 8-bit payload; lowest rot wins.
    function automatic void model(input logic [31:0] v, output bit ok,
                                  output logic [11:0] imm, output int first_r);
        longint unsigned x, rotl;
        ok = 1'b0; imm = 12'd0; first_r = -1;
        x = {v, v};
        for (int r = 0; r < 16; r++) begin
            rotl = (x >> (32 - 2 * r)) & 64'hFFFF_FFFF;
            if (!ok && rotl < 256) begin
                ok = 1'b1;
                imm = {4'(r), rotl[7:0]};
                first_r = r;
            end
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, " req_ready_a"}, 32'(req_ready_a), 32'd1);
        chk({tag, " req_ready_b"}, 32'(req_ready_b), 32'd1);
        chk({tag, " rsp_valid_a"}, 32'(rsp_valid_a), 32'd0);
        chk({tag, " rsp_valid_b"}, 32'(rsp_valid_b), 32'd0);
        chk({tag, " rsp_ok_a"},    32'(rsp_ok_a),    32'd0);
        chk({tag, " rsp_ok_b"},    32'(rsp_ok_b),    32'd0);
        chk({tag, " imm12_a"},     32'(imm12_a),     32'd0);
        chk({tag, " imm12_b"},     32'(imm12_b),     32'd0);
        chk({tag, " busy_a"},      32'(busy_a),      32'd0);
        chk({tag, " busy_b"},      32'(busy_b),      32'd0);
    endtask

    // Called #1 after a rising edge with both instances idle.
    task automatic run_txn(input logic [31:0] v, input int stall);
        bit          ok;
        logic [11:0] imm;
        int          fr, lat_a, c;
        bit          got_a, got_b;
        model(v, ok, imm, fr);
        lat_a = ok ? fr + 1 : 16;
        got_a = 1'b0; got_b = 1'b0;
        chk("accept req_ready_a", 32'(req_ready_a), 32'd1);
        chk("accept req_ready_b", 32'(req_ready_b), 32'd1);
        req_valid = 1'b1;
        req_value = v;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_value = $urandom;
        c = 0;
        while (c < 16 + stall) begin
            @(posedge clk); #1;
            c++;
            // a request while busy must be ignored
            req_valid = (c == 1);
            req_value = ~v;
            if (!got_a && rsp_valid_a) begin
                got_a = 1'b1;
                chk($sformatf("latency_a v=%h", v), 32'(c), 32'(lat_a));
            end
            if (!got_b && rsp_valid_b) begin
                got_b = 1'b1;
                chk($sformatf("latency_b v=%h", v), 32'(c), 32'd16);
            end
            if (got_a) begin
                chk($sformatf("ok_a v=%h c=%0d", v, c), 32'(rsp_ok_a), 32'(ok));
                chk($sformatf("imm_a v=%h c=%0d", v, c), 32'(imm12_a), 32'(imm));
                chk("hold valid_a", 32'(rsp_valid_a), 32'd1);
            end
            if (got_b) begin
                chk($sformatf("ok_b v=%h c=%0d", v, c), 32'(rsp_ok_b), 32'(ok));
                chk($sformatf("imm_b v=%h c=%0d", v, c), 32'(imm12_b), 32'(imm));
            end
        end
        req_valid = 1'b0;
        chk($sformatf("rsp seen a v=%h", v), 32'(got_a), 32'd1);
        chk($sformatf("rsp seen b v=%h", v), 32'(got_b), 32'd1);
        chk("busy before handshake", 32'(busy_a), 32'd1);
        chk("not ready before handshake", 32'(req_ready_b), 32'd0);
        rsp_ready_a = 1'b1;
        rsp_ready_b = 1'b1;
        @(posedge clk); #1;
        rsp_ready_a = 1'b0;
        rsp_ready_b = 1'b0;
        chk("post-hs rsp_valid_a", 32'(rsp_valid_a), 32'd0);
        chk("post-hs rsp_valid_b", 32'(rsp_valid_b), 32'd0);
        chk("post-hs req_ready_a", 32'(req_ready_a), 32'd1);
        chk("post-hs req_ready_b", 32'(req_ready_b), 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        int          rot;
        bit          seen;
        reset = 1'b0;
        req_valid = 1'b0;
        req_value = 32'd0;
        rsp_ready_a = 1'b0;
        rsp_ready_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        run_txn(32'h0000_00FF, 0);
        run_txn(32'hFF00_0000, 0);
        run_txn(32'hF000_000F, 5);
        run_txn(32'h0000_0102, 0);
        run_txn(32'h1234_5678, 5);
        run_txn(32'h0000_0000, 5);
        run_txn(32'h0000_03FC, 0);

        // reset mid-scan aborts without a response
        req_valid = 1'b1;
        req_value = 32'hFF00_0000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid-scan busy_a", 32'(busy_a), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("mid-scan reset");
        reset = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (rsp_valid_a || rsp_valid_b || busy_a || busy_b) seen = 1'b1;
        end
        chk("no response after abort", 32'(seen), 32'd0);
        run_txn(32'h0000_00FF, 0);

        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) begin
                rot = $urandom_range(0, 15);
                v = 32'($urandom_range(0, 255));
                if (rot != 0) v = (v >> (2 * rot)) | (v << (32 - 2 * rot));
            end else begin
                v = $urandom;
            end
            run_txn(v, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
